// File: rtl/tlul_pkg.sv
// TL-UL bus types and opcodes shared by the host, PMP wrapper and device targets.
// tl_h2d_t carries the A channel plus d_ready. tl_d2h_t carries the D channel plus a_ready.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_sram_pkg.sv
// Types local to the TL-UL SRAM device: the response FIFO entry and the default index width.
package tlul_sram_pkg;

    localparam int DEFAULT_MEM_WORDS = 256;
    localparam int IDX_W             = $clog2(DEFAULT_MEM_WORDS);

    typedef struct packed {
        logic [2:0]  d_opcode;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [31:0] d_data;
        logic        d_error;
    } rsp_entry_t;

endpackage

// File: rtl/tlul_sram_rsp_fifo.sv
// Response FIFO for the TL-UL SRAM device.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-low reset (pointers and count only)
//   push   in   write wdata (ignored while full)
//   wdata  in   entry to enqueue
//   pop    in   drop the head entry (ignored while empty)
//   rdata  out  head entry, valid while !empty
//   full   out  all DEPTH entries occupied
//   empty  out  no entries
module tlul_sram_rsp_fifo
    import tlul_sram_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  rsp_entry_t wdata,
    input  logic       pop,
    output rsp_entry_t rdata,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rsp_entry_t         storage [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = storage[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) storage[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tlul_sram_device.sv
// TL-UL device-side SRAM target behind the PMP wrapper.
// Executes Get / PutFullData / PutPartialData against a word array in the accept
// cycle and returns ordered responses through a small FIFO (1-cycle first latency).
// Optional macro: TLUL_SRAM_RANGE_CHECK_EN -- when defined, addresses below
// ADDR_BASE or beyond MEM_WORDS return d_error=1 without writing; otherwise the
// word index is truncated and out-of-range addresses alias.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-low reset (memory contents are kept)
//   tl_i  in   request channel from the PMP wrapper
//   tl_o  out  response channel to the PMP wrapper
module tlul_sram_device
    import tlul_pkg::*;
    import tlul_sram_pkg::*;
#(
    parameter int          MEM_WORDS = DEFAULT_MEM_WORDS,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          RSP_DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  tl_h2d_t tl_i,
    output tl_d2h_t tl_o
);

    localparam int MEM_IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [31:0]          mem [MEM_WORDS];
    logic [31:0]          offset;
    logic [MEM_IDX_W-1:0] idx;
    logic                 in_range;
    logic                 accept;
    logic                 wr_en;
    logic [3:0]           wr_mask;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    rsp_entry_t           rsp_new;
    rsp_entry_t           rsp_head;

    assign offset = tl_i.a_address - ADDR_BASE;
    assign idx    = offset[MEM_IDX_W+1:2];

`ifdef TLUL_SRAM_RANGE_CHECK_EN
    assign in_range = (tl_i.a_address >= ADDR_BASE) &&
                      ({2'b00, offset[31:2]} < 32'(MEM_WORDS));
`else
    assign in_range = 1'b1;
`endif

    // a_ready depends only on fullness, so a pop in the same cycle does not free a slot.
    assign accept = tl_i.a_valid && !fifo_full;
    assign pop    = tl_i.d_ready && !fifo_empty;

    always_comb begin
        rsp_new          = '0;
        rsp_new.d_size   = tl_i.a_size;
        rsp_new.d_source = tl_i.a_source;
        wr_mask          = 4'h0;
        case (tl_i.a_opcode)
            Get: begin
                rsp_new.d_opcode = AccessAckData;
                rsp_new.d_data   = in_range ? mem[idx] : 32'h0;
                rsp_new.d_error  = !in_range;
            end
            PutFullData: begin
                rsp_new.d_opcode = AccessAck;
                rsp_new.d_error  = !in_range;
                wr_mask          = 4'hf;
            end
            PutPartialData: begin
                rsp_new.d_opcode = AccessAck;
                rsp_new.d_error  = !in_range;
                wr_mask          = tl_i.a_mask;
            end
            default: begin
                rsp_new.d_opcode = AccessAck;
                rsp_new.d_error  = 1'b1;
            end
        endcase
    end

    assign wr_en = accept && in_range;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_mask[b]) mem[idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
        end
    end

    tlul_sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata (rsp_new),
        .pop   (pop),
        .rdata (rsp_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Fields are gated so an empty FIFO presents all zeros rather than stale storage.
    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = !fifo_full;
        if (!fifo_empty) begin
            tl_o.d_valid  = 1'b1;
            tl_o.d_opcode = rsp_head.d_opcode;
            tl_o.d_size   = rsp_head.d_size;
            tl_o.d_source = rsp_head.d_source;
            tl_o.d_data   = rsp_head.d_data;
            tl_o.d_error  = rsp_head.d_error;
        end
    end

    logic unused_sig;
    assign unused_sig = ^{offset, tl_i.a_param};

endmodule
